reg_write_arbiter: RTL and testbench
====================================

Name: reg_write_arbiter

Overview:
- Shares a bank of NREGS resettable, enabled 4-bit registers (flopenr-style: async reset, load on en) between NREQ independent writers.
- Accepts writes through valid/ready handshakes and arbitrates them round-robin.
- Issues one registered write pulse per cycle: one-hot reg_en plus a shared reg_d bus driving the bank.
- Sits between the requesting control units and the register bank; the bank itself stays outside this block.

Parameters:
- NREQ, 4, number of requesters (2..8)
- NREGS, 4, number of registers in the bank (2..16, need not be a power of two)
- WIDTH, 4, register data width
- AW, $clog2(NREGS), address width (derived, localparam)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- req_valid  input  NREQ  per-requester write request
- req_addr  input  NREQ*AW  packed target addresses, requester i at [i*AW +: AW]
- req_data  input  NREQ*WIDTH  packed write data, requester i at [i*WIDTH +: WIDTH]
- req_ready  output  NREQ  one-hot accept; a write transfers when valid&ready
- pause  input  1  blocks all acceptance while high
- reg_en  output  NREGS  one-hot write enable to the bank (registered)
- reg_d  output  WIDTH  write data to the bank (registered)
- wr_count  output  8  count of issued writes, wraps 255->0
- err_oob  output  1  sticky flag: an accepted write had addr >= NREGS

Behaviour:
- Reset (async, immediate):
  - rr_ptr=0, reg_en=0, reg_d=0, wr_count=0, err_oob=0.
  - req_ready is 0 for the reset duration.
  - A write pending from the previous accept is discarded; no pulse is issued after reset deasserts.
- Arbitration, combinational each cycle:
  - Search req_valid starting at index rr_ptr, wrapping modulo NREQ; the first set bit is granted.
  - req_ready[g]=1 iff a grant exists, pause=0 and reset=0; all other ready bits are 0.
  - req_ready never depends on req_ready; it is safe for valid to depend on nothing from this block.
- Accept, cycle N (valid&ready for requester g):
  - rr_ptr <= (g+1) mod NREQ.
  - The granted addr/data are captured.
  - If no accept occurs, rr_ptr holds.
- Issue, cycle N+1:
  - If addr < NREGS: reg_en has a single bit set at addr, reg_d=data, and wr_count increments.
  - If addr >= NREGS: reg_en stays 0, wr_count is unchanged, and err_oob sets and stays set until reset.
- Idle:
  - A cycle with no accept gives reg_en=0 on the next cycle.
  - reg_d holds its last value (not cleared).
- Throughput and latency:
  - Fully pipelined, one accept per cycle, fixed latency of 1 cycle from accept to reg_en.
  - The bank loads on the edge ending cycle N+1, so bank q shows the new value in cycle N+2.
- Requester rules:
  - Hold valid, addr and data stable until ready.
  - May drop valid only after the transfer.
  - This block does not check these rules.
- Fairness: with all requesters continuously valid, grants rotate 0,1,..,NREQ-1,0,...; no requester waits more than NREQ-1 accepts.
- pause:
  - While high, no accepts occur, rr_ptr freezes, and reg_en is 0 on the following cycle.
  - A write already accepted in the cycle before pause rises still issues.
- Same-register writes: back-to-back writes to the same register issue in acceptance order, so the last accepted value wins.
- wr_count wraps 255->0 with no flag.

Decomposition:
- Package reg_write_arbiter_pkg holds:
  - the wr_count width constant (8)
  - a typedef for the issue-stage record {valid, addr, data}
  - a function for the rotated first-one search, reused by other arbiters.
- Sub-module rr_arbiter (parameter N): inputs clk, reset, req, advance; output one-hot grant.
  - It owns rr_ptr.
  - The top level owns the handshake, issue register, counter and error flag.

Test Plan:
- Reset, then requester 1 writes addr 2, data 4'hA -> ready[1] same cycle; next cycle reg_en=4'b0100, reg_d=4'hA, wr_count=1.
- All 4 requesters valid for 8 cycles, each with addr=i, data=i+5 -> grant order 0,1,2,3,0,1,2,3; reg_en walks 0001,0010,0100,1000 twice; wr_count=8.
- pause high for 3 cycles with requester 0 valid -> ready=0 and reg_en=0 throughout; after pause drops, requester 0 is accepted first and rr_ptr is unchanged.
- NREGS=3, requester 2 writes addr 3 -> accepted, reg_en stays 0, err_oob=1 and sticky; wr_count unchanged.
- Assert reset in the cycle after an accept -> reg_en=0 immediately, no pulse after release, rr_ptr=0, wr_count=0.
- 256 writes from one requester -> wr_count wraps to 0; the last reg_d matches the last data written.

Source files
------------

// File: rtl/reg_write_arbiter_pkg.sv
// Shared types, constants and the rotated first-one search for the register write arbiter.
package reg_write_arbiter_pkg;

  // Width of the issued-write counter
  localparam int unsigned CNT_W  = 8;

  // Issue record field widths: wide enough for any supported address/data width
  localparam int unsigned ISS_AW = 5;
  localparam int unsigned ISS_DW = 32;

  // Largest requester vector the first-one search handles
  localparam int unsigned RR_MAX = 16;
  localparam int unsigned RR_IW  = $clog2(RR_MAX);

  // One accepted write on its way to the bank
  typedef struct packed {
    logic              valid;
    logic [ISS_AW-1:0] addr;
    logic [ISS_DW-1:0] data;
  } issue_t;

  // Returns a one-hot vector marking the first set bit of req at or after ptr,
  // wrapping modulo n; all zeros when no bit below n is set. Requires ptr < n <= RR_MAX.
  function automatic logic [RR_MAX-1:0] rr_first(input logic [RR_MAX-1:0] req,
                                                  input int unsigned       ptr,
                                                  input int unsigned       n);
    logic [RR_MAX-1:0] g;
    logic              found;
    int unsigned       idx;
    g     = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < RR_MAX; k++) begin
      idx = ptr + k;
      if (idx >= n) idx = idx - n;
      if ((k < n) && !found && req[RR_IW'(idx)]) begin
        g[RR_IW'(idx)] = 1'b1;
        found          = 1'b1;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/reg_write_arbiter_rr.sv
// Round-robin arbiter: one-hot grant searched from rr_ptr; the pointer moves past
// the granted requester whenever the grant is consumed.
module rr_arbiter
  import reg_write_arbiter_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] gidx_c;
  logic [PW-1:0] ptr_nxt_c;

  // Rotated first-one search starting at rr_ptr
  always_comb begin
    grant = N'(rr_first(RR_MAX'(req), 32'(rr_ptr), N));
  end

  // Encode the grant and compute the slot after it, wrapping at N
  always_comb begin
    gidx_c = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (grant[i]) gidx_c = PW'(i);
    end
    ptr_nxt_c = (gidx_c == PW'(N - 1)) ? '0 : gidx_c + PW'(1);
  end

  // Pointer advances only on a consumed grant
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (advance) begin
      rr_ptr <= ptr_nxt_c;
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin write arbiter in front of a bank of enabled registers: accepts one
// write per cycle over valid/ready and issues it as a registered one-hot pulse.
module reg_write_arbiter
  import reg_write_arbiter_pkg::*;
#(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned NREGS = 4,
  parameter int unsigned WIDTH = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NREQ-1:0]                 req_valid,
  input  logic [NREQ*$clog2(NREGS)-1:0]   req_addr,
  input  logic [NREQ*WIDTH-1:0]           req_data,
  output logic [NREQ-1:0]                 req_ready,
  input  logic                            pause,
  output logic [NREGS-1:0]                reg_en,
  output logic [WIDTH-1:0]                reg_d,
  output logic [CNT_W-1:0]                wr_count,
  output logic                            err_oob
);

  localparam int unsigned AW = $clog2(NREGS);

  logic [NREQ-1:0]  grant;
  logic             accept_c;
  issue_t           acc_c;
  logic             in_range_c;
  logic [NREGS-1:0] en_c;

  rr_arbiter #(
    .N(NREQ)
  ) u_rr (
    .clk    (clk),
    .reset  (reset),
    .req    (req_valid),
    .advance(accept_c),
    .grant  (grant)
  );

  // Ready goes only to the granted requester, and never while paused or in reset
  always_comb begin
    req_ready = grant & {NREQ{~pause & ~reset}};
    accept_c  = |(req_valid & req_ready);
  end

  // Select the accepted requester's address and data
  always_comb begin
    acc_c       = '0;
    acc_c.valid = accept_c;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (req_ready[i]) begin
        acc_c.addr = ISS_AW'(req_addr[i*AW +: AW]);
        acc_c.data = ISS_DW'(req_data[i*WIDTH +: WIDTH]);
      end
    end
  end

  // Range check and one-hot decode of the accepted address
  always_comb begin
    in_range_c = 32'(acc_c.addr) < NREGS;
    en_c       = '0;
    for (int unsigned r = 0; r < NREGS; r++) begin
      en_c[r] = (acc_c.addr == ISS_AW'(r));
    end
  end

  // Issue stage: pulse, data, counter and sticky out-of-range flag, one cycle after accept
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reg_en   <= '0;
      reg_d    <= '0;
      wr_count <= '0;
      err_oob  <= 1'b0;
    end else begin
      reg_en <= '0;
      if (acc_c.valid) begin
        if (in_range_c) begin
          reg_en   <= en_c;
          reg_d    <= WIDTH'(acc_c.data);
          wr_count <= wr_count + CNT_W'(1);
        end else begin
          err_oob  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Bench for reg_write_arbiter: two instances (4 and 3 registers) share one stimulus,
// checked every cycle against a queue-free behavioural model plus literal spot checks.
module tb_reg_write_arbiter;

  localparam int NREQ = 4;
  localparam int AW   = 2;
  localparam int W    = 4;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*AW-1:0]   req_addr;
  logic [NREQ*W-1:0]    req_data;
  logic                 pause;
  logic [NREQ-1:0]      ready_a, ready_b;
  logic [3:0]           reg_en_a;
  logic [2:0]           reg_en_b;
  logic [W-1:0]         reg_d_a, reg_d_b;
  logic [7:0]           cnt_a, cnt_b;
  logic                 err_a, err_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  reg_write_arbiter #(.NREQ(4), .NREGS(4), .WIDTH(4)) dut_a (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_ready(ready_a), .pause(pause), .reg_en(reg_en_a),
    .reg_d(reg_d_a), .wr_count(cnt_a), .err_oob(err_a));

  reg_write_arbiter #(.NREQ(4), .NREGS(3), .WIDTH(4)) dut_b (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_ready(ready_b), .pause(pause), .reg_en(reg_en_b),
    .reg_d(reg_d_b), .wr_count(cnt_b), .err_oob(err_b));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_ptr;
  int          m_g;
  int          m_a, m_d;
  logic [3:0]  m_rdy;
  int          e_en  [2];
  int          e_d   [2];
  int          e_cnt [2];
  int          e_err [2];
  int          nregs [2] = '{4, 3};

  always @(negedge clk) begin
    if (reset) begin
      m_ptr = 0;
      for (int d = 0; d < 2; d++) begin
        e_en[d] = 0; e_d[d] = 0; e_cnt[d] = 0; e_err[d] = 0;
      end
    end
    // grant: first valid requester at or after the pointer, cyclically
    m_g = -1;
    if (!reset && !pause) begin
      for (int k = 0; k < NREQ; k++) begin
        if (m_g < 0 && req_valid[(m_ptr + k) % NREQ]) m_g = (m_ptr + k) % NREQ;
      end
    end
    m_rdy = (m_g >= 0) ? 4'(1 << m_g) : 4'd0;

    chk("a.ready",  32'(ready_a),  32'(m_rdy));
    chk("b.ready",  32'(ready_b),  32'(m_rdy));
    chk("a.reg_en", 32'(reg_en_a), 32'(e_en[0]));
    chk("b.reg_en", 32'(reg_en_b), 32'(e_en[1]));
    chk("a.reg_d",  32'(reg_d_a),  32'(e_d[0]));
    chk("b.reg_d",  32'(reg_d_b),  32'(e_d[1]));
    chk("a.count",  32'(cnt_a),    32'(e_cnt[0]));
    chk("b.count",  32'(cnt_b),    32'(e_cnt[1]));
    chk("a.err",    32'(err_a),    32'(e_err[0]));
    chk("b.err",    32'(err_b),    32'(e_err[1]));

    // what the outputs must show in the next cycle
    if (!reset) begin
      for (int d = 0; d < 2; d++) e_en[d] = 0;
      if (m_g >= 0) begin
        m_a   = int'(req_addr[m_g*AW +: AW]);
        m_d   = int'(req_data[m_g*W +: W]);
        m_ptr = (m_g + 1) % NREQ;
        for (int d = 0; d < 2; d++) begin
          if (m_a < nregs[d]) begin
            e_en[d]  = 1 << m_a;
            e_d[d]   = m_d;
            e_cnt[d] = (e_cnt[d] + 1) % 256;
          end else begin
            e_err[d] = 1;
          end
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_req(input int i, input int a, input int d);
    req_valid[i]         = 1'b1;
    req_addr[i*AW +: AW] = AW'(a);
    req_data[i*W +: W]   = W'(d);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step();
    reset = 1'b1; req_valid = '0; pause = 1'b0;
    step();
    reset = 1'b0;
  endtask

  logic [3:0] exp4;
  logic [3:0] acc;
  int         last_d;

  initial begin
    reset = 1'b1; pause = 1'b0; req_valid = 4'hF; req_addr = '0; req_data = '0;

    // reset holds ready low even with every requester valid
    @(negedge clk);
    chk("rst.ready", 32'(ready_a), 32'h0);
    chk("rst.count", 32'(cnt_a), 32'h0);

    // single write: requester 1 -> addr 2, data A
    step(); reset = 1'b0; req_valid = '0;
    set_req(1, 2, 4'hA);
    @(negedge clk); chk("t1.ready", 32'(ready_a), 32'h2);
    step(); req_valid = '0;
    @(negedge clk);
    chk("t1.reg_en", 32'(reg_en_a), 32'h4);
    chk("t1.reg_d",  32'(reg_d_a),  32'hA);
    chk("t1.count",  32'(cnt_a),    32'h1);

    // all requesters valid: grants rotate, reg_en walks
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, i, i + 5);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      exp4 = 4'(1 << (k % 4));
      chk("rot.ready", 32'(ready_a), 32'(exp4));
      if (k > 0) begin
        exp4 = 4'(1 << ((k - 1) % 4));
        chk("rot.reg_en", 32'(reg_en_a), 32'(exp4));
      end
      step();
    end
    req_valid = '0;
    @(negedge clk);
    chk("rot.last_en", 32'(reg_en_a), 32'h8);
    chk("rot.count",   32'(cnt_a),    32'd8);
    chk("rot.reg_d",   32'(reg_d_a),  32'd8);

    // pause: in-flight write still issues, then nothing until release
    do_reset();
    set_req(1, 1, 4'h6);
    step(); req_valid = '0; pause = 1'b1; set_req(0, 0, 4'h9);
    @(negedge clk);
    chk("pause.ready0", 32'(ready_a), 32'h0);
    chk("pause.inflt",  32'(reg_en_a), 32'h2);
    for (int k = 0; k < 2; k++) begin
      step();
      @(negedge clk);
      chk("pause.ready", 32'(ready_a), 32'h0);
      chk("pause.en",    32'(reg_en_a), 32'h0);
    end
    step(); pause = 1'b0;
    @(negedge clk); chk("pause.rel_ready", 32'(ready_a), 32'h1);
    step(); req_valid = '0;
    @(negedge clk);
    chk("pause.rel_en",  32'(reg_en_a), 32'h1);
    chk("pause.rel_cnt", 32'(cnt_a),    32'd2);

    // out-of-range address on the 3-register instance
    do_reset();
    set_req(2, 3, 4'h7);
    @(negedge clk); chk("oob.ready", 32'(ready_b), 32'h4);
    step(); req_valid = '0;
    @(negedge clk);
    chk("oob.b_en",  32'(reg_en_b), 32'h0);
    chk("oob.b_err", 32'(err_b),    32'h1);
    chk("oob.b_cnt", 32'(cnt_b),    32'h0);
    chk("oob.a_en",  32'(reg_en_a), 32'h8);
    chk("oob.a_err", 32'(err_a),    32'h0);
    repeat (3) step();
    set_req(0, 1, 4'h2);
    step(); req_valid = '0;
    @(negedge clk);
    chk("oob.sticky", 32'(err_b),    32'h1);
    chk("oob.b_en2",  32'(reg_en_b), 32'h2);
    chk("oob.b_cnt2", 32'(cnt_b),    32'h1);

    // reset in the issue cycle kills the pulse at once
    do_reset();
    set_req(0, 1, 4'h3);
    step(); req_valid = '0;
    chk("rstmid.pre_en", 32'(reg_en_a), 32'h2);
    reset = 1'b1;
    #1;
    chk("rstmid.en",  32'(reg_en_a), 32'h0);
    chk("rstmid.cnt", 32'(cnt_a),    32'h0);
    step(); reset = 1'b0;
    set_req(0, 0, 4'h1); set_req(1, 0, 4'h2);
    @(negedge clk);
    chk("rstmid.post_en", 32'(reg_en_a), 32'h0);
    chk("rstmid.ptr0",    32'(ready_a),  32'h1);
    step(); req_valid = '0;

    // 256 writes from one requester: counter wraps to zero
    do_reset();
    last_d = 0;
    for (int n = 0; n < 256; n++) begin
      last_d = int'($urandom_range(0, 15));
      set_req(1, int'($urandom_range(0, 2)), last_d);
      if (n == 255) begin
        @(negedge clk);
        chk("wrap.255", 32'(cnt_a), 32'd255);
      end
      step();
    end
    req_valid = '0;
    @(negedge clk);
    chk("wrap.cnt_a", 32'(cnt_a),   32'd0);
    chk("wrap.cnt_b", 32'(cnt_b),   32'd0);
    chk("wrap.reg_d", 32'(reg_d_a), 32'(last_d));

    // randomized traffic honouring the hold-until-ready rule
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      acc = req_valid & ready_a;
      step();
      reset = ($urandom_range(0, 99) < 2);
      pause = ($urandom_range(0, 99) < 15);
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] || acc[i]) begin
          if ($urandom_range(0, 99) < 60) set_req(i, int'($urandom_range(0, 3)), int'($urandom_range(0, 15)));
          else req_valid[i] = 1'b0;
        end
      end
    end
    reset = 1'b0; pause = 1'b0; req_valid = '0;
    repeat (3) step();
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
